// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo_flags #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = 6,
  parameter  int AE_LEVEL = 2,
  parameter  int FWFT     = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             r_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0]   C_ZERO    = {(AW+1){1'b0}};
  localparam logic [AW:0]   C_ONE     = (AW+1)'(1'b1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1'b1);
  localparam logic [AW:0]   C_DEPTH   = DEPTH[AW:0];
  localparam logic [AW:0]   C_AF      = AF_LEVEL[AW:0];
  localparam logic [AW:0]   C_AE      = AE_LEVEL[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic             r_udf;
  logic [AW:0]      w_count_nxt;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_empty;
  logic             w_full;

  assign w_empty = (r_count == C_ZERO);
  assign w_full  = (r_count == C_DEPTH);
  // A write into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign w_rd_ok = r_en & ~w_empty;
  assign w_wr_ok = w_en & (~w_full | w_rd_ok);

  // Occupancy next-state: up/down counter, unchanged on simultaneous accept.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= C_ZERO;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      r_count <= w_count_nxt;
      r_ovf   <= w_en & ~w_wr_ok;
      r_udf   <= r_en & ~w_rd_ok;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = w_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] r_dout;

      // Registered read port: the popped word appears one cycle after r_en.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_dout <= {WIDTH{1'b0}};
        end else if (w_rd_ok) begin
          r_dout <= r_mem[r_rd_ptr];
        end else begin
          r_dout <= r_dout;
        end
      end

      assign data_out = r_dout;
    end
  endgenerate

  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags: a standard-read instance and
// an FWFT instance, with a small queue scoreboard for the interleaved phase.
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst;
  logic       w_en0, r_en0, w_en1, r_en1;
  logic [7:0] din0, din1, dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] cnt0, cnt1;

  int n_checks = 0;
  int n_pass   = 0;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en0), .data_in(din0), .r_en(r_en0),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en1), .data_in(din1), .r_en(r_en1),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // Drive one cycle on the standard instance and sample 1 time unit after the edge.
  task automatic step0(input logic w, input logic r, input logic [7:0] d);
    w_en0 = w; r_en0 = r; din0 = d;
    @(posedge clk); #1;
    w_en0 = 1'b0; r_en0 = 1'b0;
  endtask

  task automatic step1(input logic w, input logic r, input logic [7:0] d);
    w_en1 = w; r_en1 = r; din1 = d;
    @(posedge clk); #1;
    w_en1 = 1'b0; r_en1 = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_dout;
  logic       rw, rr, m_rd_ok, m_wr_ok;
  logic [7:0] rd;

  initial begin
    rst = 1'b0;
    w_en0 = 1'b0; r_en0 = 1'b0; din0 = 8'h00;
    w_en1 = 1'b0; r_en1 = 1'b0; din1 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(cnt0), 32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_ae", 32'(ae0), 32'd1);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_af", 32'(af0), 32'd0);
    check("rst_dout", 32'(dout0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_udf", 32'(udf0), 32'd0);
    check("rst_fwft_dout", 32'(dout1), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Fill 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      step0(1'b1, 1'b0, 8'h10 + 8'(i));
      check("fill_count", 32'(cnt0), 32'(i + 1));
      check("fill_af", 32'(af0), 32'((i + 1) >= 6));
      check("fill_full", 32'(full0), 32'((i + 1) == 8));
      check("fill_ae", 32'(ae0), 32'((i + 1) <= 2));
    end
    step0(1'b1, 1'b0, 8'h99);
    check("ovf_pulse", 32'(ovf0), 32'd1);
    check("ovf_count", 32'(cnt0), 32'd8);
    step0(1'b0, 1'b0, 8'h00);
    check("ovf_clear", 32'(ovf0), 32'd0);

    // Drain
    for (int i = 0; i < 8; i++) begin
      step0(1'b0, 1'b1, 8'h00);
      check("drain_dout", 32'(dout0), 32'(8'h10 + 8'(i)));
      check("drain_count", 32'(cnt0), 32'(7 - i));
      check("drain_empty", 32'(empty0), 32'(i == 7));
    end
    step0(1'b0, 1'b1, 8'h00);
    check("udf_pulse", 32'(udf0), 32'd1);
    check("udf_hold", 32'(dout0), 32'h17);
    step0(1'b0, 1'b0, 8'h00);
    check("udf_clear", 32'(udf0), 32'd0);

    // Simultaneous at count 4
    for (int i = 0; i < 4; i++) step0(1'b1, 1'b0, 8'h20 + 8'(i));
    step0(1'b1, 1'b1, 8'h24);
    check("rw4_count", 32'(cnt0), 32'd4);
    check("rw4_dout", 32'(dout0), 32'h20);
    check("rw4_ovf", 32'(ovf0), 32'd0);
    for (int i = 0; i < 4; i++) step0(1'b1, 1'b0, 8'h25 + 8'(i));
    check("rwf_pre_full", 32'(full0), 32'd1);
    step0(1'b1, 1'b1, 8'h29);
    check("rwf_count", 32'(cnt0), 32'd8);
    check("rwf_dout", 32'(dout0), 32'h21);
    check("rwf_ovf", 32'(ovf0), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step0(1'b0, 1'b1, 8'h00);
      check("rwf_order", 32'(dout0), 32'(8'h22 + 8'(i)));
    end
    check("rwf_empty", 32'(empty0), 32'd1);

    // Simultaneous at empty
    step0(1'b1, 1'b1, 8'h3C);
    check("rwe_count", 32'(cnt0), 32'd1);
    check("rwe_udf", 32'(udf0), 32'd1);
    check("rwe_hold", 32'(dout0), 32'h29);
    step0(1'b0, 1'b1, 8'h00);
    check("rwe_read", 32'(dout0), 32'h3C);
    check("rwe_count0", 32'(cnt0), 32'd0);
    check("rwe_udf_clr", 32'(udf0), 32'd0);

    // Interleaved random push/pop against a queue model
    exp_dout = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      rw = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rd = 8'($urandom_range(0, 255));
      m_rd_ok = rr & (q.size() > 0);
      m_wr_ok = rw & ((q.size() < 8) | m_rd_ok);
      if (m_rd_ok) exp_dout = q.pop_front();
      if (m_wr_ok) q.push_back(rd);
      step0(rw, rr, rd);
      check("rnd_count", 32'(cnt0), 32'(q.size()));
      check("rnd_dout", 32'(dout0), 32'(exp_dout));
    end
    while (q.size() > 0) begin
      exp_dout = q.pop_front();
      step0(1'b0, 1'b1, 8'h00);
      check("rnd_flush", 32'(dout0), 32'(exp_dout));
    end

    // Reset mid-fill at count 5
    for (int i = 0; i < 6; i++) step0(1'b1, 1'b0, 8'h50 + 8'(i));
    step0(1'b0, 1'b1, 8'h00);
    check("mid_count5", 32'(cnt0), 32'd5);
    check("mid_dout", 32'(dout0), 32'h50);
    rst = 1'b0;
    #1;
    check("mid_rst_count", 32'(cnt0), 32'd0);
    check("mid_rst_empty", 32'(empty0), 32'd1);
    check("mid_rst_dout", 32'(dout0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // FWFT instance
    check("fwft_empty0", 32'(empty1), 32'd1);
    step1(1'b1, 1'b0, 8'hA5);
    check("fwft_show", 32'(dout1), 32'hA5);
    check("fwft_count1", 32'(cnt1), 32'd1);
    step1(1'b0, 1'b1, 8'h00);
    check("fwft_pop_dout", 32'(dout1), 32'd0);
    check("fwft_pop_empty", 32'(empty1), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
